// File: rtl/sqrt_ctrl_pkg.sv
// Shared types and defaults for the square-root pipeline controller.
package sqrt_ctrl_pkg;

  localparam int STATE_W    = 2;
  localparam int DEF_STAGES = 4;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/sqrt_valid_chain.sv
// Per-stage valid bits; all stages advance together on the shared enable.
module sqrt_valid_chain
  import sqrt_ctrl_pkg::*;
#(
  parameter int STAGES = DEF_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              din,
  output logic [STAGES-1:0] v_o,
  output logic [STAGES-1:0] v_next_o
);

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;

  // clear wins over shift; a disabled chain holds so stalled results stay put
  always_comb begin
    v_d = v_q;
    if (clr) begin
      v_d = '0;
    end else if (en) begin
      v_d = {v_q[STAGES-2:0], din};
    end else begin
      v_d = v_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  assign v_o      = v_q;
  assign v_next_o = v_d;

endmodule

// File: rtl/sqrt_pipe_ctrl.sv
// Square-root pipeline controller: global stage enable, valid/ready handshakes,
// flush sequencing and a wrapping completed-result counter.
module sqrt_pipe_ctrl
  import sqrt_ctrl_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               en_pipe_o,
  output logic [STAGES-1:0]  stage_valid_o,
  output logic               busy_o,
  output logic [CNT_W-1:0]   done_cnt_o,
  output logic [STATE_W-1:0] state_o
);

  state_e            state_q;
  state_e            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [STAGES-1:0] v_s;
  logic [STAGES-1:0] v_next_s;
  logic              stall_s;
  logic              accept_s;
  logic              deliver_s;

  assign out_valid_o = v_s[STAGES-1];
  assign stall_s     = out_valid_o & ~out_ready_i;
  assign en_pipe_o   = ~stall_s;
  // rst gates ready combinationally so nothing is accepted while reset is held
  assign in_ready_o  = en_pipe_o & (state_q != ST_FLUSH) & ~flush_i & ~rst;
  assign accept_s    = in_valid_i & in_ready_o;
  assign deliver_s   = out_valid_o & out_ready_i;

  sqrt_valid_chain #(
    .STAGES(STAGES)
  ) u_chain (
    .clk      (clk),
    .rst      (rst),
    .en       (en_pipe_o),
    .clr      (flush_i),
    .din      (accept_s),
    .v_o      (v_s),
    .v_next_o (v_next_s)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          state_d = ST_FLUSH;
        end else if (accept_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (flush_i) begin
          state_d = ST_FLUSH;
        end else if (v_next_s == '0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (flush_i) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // a deliver in the flush cycle still counts; the counter wraps silently
  always_comb begin
    cnt_d = cnt_q;
    if (deliver_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stage_valid_o = v_s;
  assign busy_o        = |v_s;
  assign done_cnt_o    = cnt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_sqrt_pipe_ctrl.sv
// Self-checking bench for sqrt_pipe_ctrl against a queue-of-operands reference model.
module tb_sqrt_pipe_ctrl;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush_i = 1'b0;
  logic       in_valid_i = 1'b0;
  logic       out_ready_i = 1'b0;
  logic       in_ready_o, out_valid_o, en_pipe_o, busy_o;
  logic [3:0] stage_valid_o;
  logic [7:0] done_cnt_o;
  logic [1:0] state_o;

  logic       in_ready2, out_valid2, en_pipe2, busy2;
  logic [3:0] stage_valid2;
  logic [1:0] done_cnt2;
  logic [1:0] state2;

  int n_checks = 0;
  int n_fail = 0;

  // model: each in-flight operand is its stage position 1..S, oldest first
  int q[$];
  int m_state;
  int m_cnt;

  sqrt_pipe_ctrl #(.STAGES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .en_pipe_o(en_pipe_o), .stage_valid_o(stage_valid_o), .busy_o(busy_o),
    .done_cnt_o(done_cnt_o), .state_o(state_o)
  );

  sqrt_pipe_ctrl #(.STAGES(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready2), .out_valid_o(out_valid2), .out_ready_i(out_ready_i),
    .en_pipe_o(en_pipe2), .stage_valid_o(stage_valid2), .busy_o(busy2),
    .done_cnt_o(done_cnt2), .state_o(state2)
  );

  always #5 clk = ~clk;

  function automatic bit m_ov();
    foreach (q[i]) if (q[i] == S) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_sv();
    logic [3:0] r = 4'b0000;
    foreach (q[i]) r[q[i]-1] = 1'b1;
    return r;
  endfunction

  function automatic bit m_en(input logic ordy);
    return !(m_ov() && !ordy);
  endfunction

  function automatic bit m_rdy(input logic fl, input logic ordy);
    return m_en(ordy) && (m_state != 2) && !fl;
  endfunction

  task automatic model_reset();
    q.delete();
    m_state = 0;
    m_cnt = 0;
  endtask

  task automatic model_step(input logic iv, input logic fl, input logic ordy);
    bit en  = m_en(ordy);
    bit acc = iv && m_rdy(fl, ordy);
    bit dlv = m_ov() && ordy;
    if (dlv) m_cnt = (m_cnt + 1) % 256;
    if (fl) begin
      q.delete();
      m_state = 2;
    end else begin
      if (en) begin
        if (dlv) void'(q.pop_front());
        foreach (q[i]) q[i] = q[i] + 1;
        if (acc) q.push_back(1);
      end
      if (m_state == 0) m_state = acc ? 1 : 0;
      else if (m_state == 1) m_state = (q.size() == 0) ? 0 : 1;
      else m_state = 0;
    end
  endtask

  // drive inputs mid-cycle and let combinational outputs settle before checks
  task automatic drive(input logic iv, input logic fl, input logic ordy);
    @(negedge clk);
    in_valid_i = iv;
    flush_i = fl;
    out_ready_i = ordy;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++; if (stage_valid_o !== 4'h0) begin n_fail++; $display("FAIL reset_sv got %h want 0", stage_valid_o); end
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_ov got %b want 0", out_valid_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_checks++; if (done_cnt_o !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", done_cnt_o); end
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state_o); end
    n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready_o); end
    n_checks++; if (en_pipe_o !== 1'b1) begin n_fail++; $display("FAIL reset_en_pipe got %b want 1", en_pipe_o); end
    rst = 1'b0;
    in_valid_i = 1'b0;
    model_reset();
  endtask

  task automatic test_single_op();
    int base = m_cnt;
    drive(1'b1, 1'b0, 1'b1);
    n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_in_ready got %b want 1", in_ready_o); end
    model_step(1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (out_valid_o !== (k == 4)) begin
        n_fail++; $display("FAIL single_latency k=%0d got %b want %b", k, out_valid_o, (k == 4));
      end
      model_step(1'b0, 1'b0, 1'b1);
    end
    n_checks++; if (done_cnt_o !== 8'((base + 1) % 256)) begin n_fail++; $display("FAIL single_cnt got %0d want %0d", done_cnt_o, (base + 1) % 256); end
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL single_idle got %0d want 0", state_o); end
  endtask

  task automatic test_streaming();
    int base = m_cnt;
    int nv = 0;
    int first = -1;
    int last = -1;
    for (int k = 0; k < 18; k++) begin
      drive(k < 10, 1'b0, 1'b1);
      if (out_valid_o === 1'b1) begin
        nv++;
        if (first < 0) first = k;
        last = k;
      end
      model_step(k < 10, 1'b0, 1'b1);
    end
    n_checks++; if (nv != 10) begin n_fail++; $display("FAIL stream_count got %0d want 10", nv); end
    n_checks++; if (last - first != 9) begin n_fail++; $display("FAIL stream_consecutive got span %0d want 9", last - first); end
    n_checks++; if (first != 4) begin n_fail++; $display("FAIL stream_first got %0d want 4", first); end
    n_checks++; if (done_cnt_o !== 8'((base + 10) % 256)) begin n_fail++; $display("FAIL stream_cnt got %0d want %0d", done_cnt_o, (base + 10) % 256); end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      model_step(1'b1, 1'b0, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      n_checks++; if (en_pipe_o !== 1'b0) begin n_fail++; $display("FAIL bp_en_pipe k=%0d got %b want 0", k, en_pipe_o); end
      n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready k=%0d got %b want 0", k, in_ready_o); end
      n_checks++; if (stage_valid_o !== 4'hF) begin n_fail++; $display("FAIL bp_sv k=%0d got %h want f", k, stage_valid_o); end
      model_step(1'b1, 1'b0, 1'b0);
    end
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b0, 1'b1);
      model_step(1'b0, 1'b0, 1'b1);
    end
    n_checks++; if (stage_valid_o !== 4'h0) begin n_fail++; $display("FAIL bp_drained got %h want 0", stage_valid_o); end
  endtask

  task automatic test_flush_stalled();
    logic [3:0] pat = 4'b1101;
    int base;
    for (int k = 0; k < 4; k++) begin
      drive(pat[k], 1'b0, 1'b0);
      model_step(pat[k], 1'b0, 1'b0);
    end
    base = m_cnt;
    drive(1'b0, 1'b0, 1'b0);
    n_checks++; if (stage_valid_o !== 4'hB) begin n_fail++; $display("FAIL flush_pre_sv got %h want b", stage_valid_o); end
    model_step(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %b want 0", in_ready_o); end
    model_step(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    n_checks++; if (stage_valid_o !== 4'h0) begin n_fail++; $display("FAIL flush_sv got %h want 0", stage_valid_o); end
    n_checks++; if (state_o !== 2'd2) begin n_fail++; $display("FAIL flush_state got %0d want 2", state_o); end
    n_checks++; if (en_pipe_o !== 1'b1 || in_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_hs got en=%b rdy=%b want en=1 rdy=0", en_pipe_o, in_ready_o); end
    model_step(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL flush_idle got %0d want 0", state_o); end
    n_checks++; if (done_cnt_o !== 8'(base)) begin n_fail++; $display("FAIL flush_cnt got %0d want %0d", done_cnt_o, base); end
    model_step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_flush_deliver();
    int base;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      model_step(1'b1, 1'b0, 1'b0);
    end
    base = m_cnt;
    drive(1'b0, 1'b1, 1'b1);
    n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL fd_ov got %b want 1", out_valid_o); end
    model_step(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    n_checks++; if (done_cnt_o !== 8'((base + 1) % 256)) begin n_fail++; $display("FAIL fd_cnt got %0d want %0d", done_cnt_o, (base + 1) % 256); end
    n_checks++; if (stage_valid_o !== 4'h0) begin n_fail++; $display("FAIL fd_sv got %h want 0", stage_valid_o); end
    model_step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_counter_wrap();
    logic [1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    int idx = 0;
    bit prev_dlv = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    for (int k = 0; k < 14; k++) begin
      drive(k < 5, 1'b0, 1'b1);
      if (prev_dlv && idx < 5) begin
        n_checks++;
        if (done_cnt2 !== exp_seq[idx]) begin
          n_fail++; $display("FAIL wrap_seq idx=%0d got %0d want %0d", idx, done_cnt2, exp_seq[idx]);
        end
        idx++;
      end
      prev_dlv = m_ov() && 1'b1;
      model_step(k < 5, 1'b0, 1'b1);
    end
    n_checks++; if (idx != 5) begin n_fail++; $display("FAIL wrap_deliveries got %0d want 5", idx); end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 1'b0, 1'b1);
      model_step(1'b1, 1'b0, 1'b1);
    end
    @(negedge clk);
    in_valid_i = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (stage_valid_o !== 4'h0 || busy_o !== 1'b0 || out_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_valid got sv=%h busy=%b ov=%b want 0", stage_valid_o, busy_o, out_valid_o); end
    n_checks++; if (done_cnt_o !== 8'd0) begin n_fail++; $display("FAIL arst_cnt got %0d want 0", done_cnt_o); end
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL arst_state got %0d want 0", state_o); end
    n_checks++; if (in_ready_o !== 1'b0 || en_pipe_o !== 1'b1) begin n_fail++; $display("FAIL arst_hs got rdy=%b en=%b want rdy=0 en=1", in_ready_o, en_pipe_o); end
    #1 rst = 1'b0;
    in_valid_i = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic iv, fl, ordy;
    for (int k = 0; k < 400; k++) begin
      iv = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 15) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      drive(iv, fl, ordy);
      n_checks++; if (stage_valid_o !== m_sv()) begin n_fail++; $display("FAIL rnd_sv k=%0d got %h want %h", k, stage_valid_o, m_sv()); end
      n_checks++; if (out_valid_o !== m_ov() || busy_o !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_ov_busy k=%0d got ov=%b busy=%b want ov=%b busy=%b", k, out_valid_o, busy_o, m_ov(), q.size() != 0); end
      n_checks++; if (en_pipe_o !== m_en(ordy) || in_ready_o !== m_rdy(fl, ordy)) begin n_fail++; $display("FAIL rnd_hs k=%0d got en=%b rdy=%b want en=%b rdy=%b", k, en_pipe_o, in_ready_o, m_en(ordy), m_rdy(fl, ordy)); end
      n_checks++; if (state_o !== 2'(m_state)) begin n_fail++; $display("FAIL rnd_state k=%0d got %0d want %0d", k, state_o, m_state); end
      n_checks++; if (done_cnt_o !== 8'(m_cnt) || done_cnt2 !== 2'(m_cnt % 4)) begin n_fail++; $display("FAIL rnd_cnt k=%0d got %0d/%0d want %0d/%0d", k, done_cnt_o, done_cnt2, m_cnt, m_cnt % 4); end
      model_step(iv, fl, ordy);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_op();
    test_streaming();
    test_backpressure();
    test_flush_stalled();
    test_flush_deliver();
    test_counter_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
